alu16: RTL and testbench

ALU16 -- requirements
Module: alu16

---
 rtl/alu16.sv | 150 +++++++++++++++
 tb/tb_alu16.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu16.sv
// 16-bit registered ALU: one operation per clock, result and Z/S/C/V flags valid one edge later.
// Optional SWAP/NEG operations on FSEL E/F are enabled by defining ALU16_EXT_OPS_EN.
module alu16 #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [DATA_W-1:0] ABUS,
  input  logic [DATA_W-1:0] BBUS,
  input  logic [3:0]        FSEL,
  input  logic              CIN,
  output logic [DATA_W-1:0] FOUT,
  output logic              Z,
  output logic              S,
  output logic              C,
  output logic              V
);

  localparam logic [3:0] OP_TSA = 4'h0;
  localparam logic [3:0] OP_INC = 4'h1;
  localparam logic [3:0] OP_DEC = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;
  localparam logic [3:0] OP_RLC = 4'hC;
  localparam logic [3:0] OP_RRC = 4'hD;
`ifdef ALU16_EXT_OPS_EN
  localparam logic [3:0] OP_SWAP = 4'hE;
  localparam logic [3:0] OP_NEG  = 4'hF;
  localparam logic [DATA_W-1:0] ZERO = '0;
`endif

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  localparam int HALF = DATA_W / 2;

  // Returns {carry_or_borrow, signed_overflow, wrapped_result}. Carry comes from an
  // unsigned extended sum, overflow from a sign-extended signed sum disagreeing with
  // its own truncated sign bit.
  function automatic logic [DATA_W+1:0] add_sub(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sub
  );
    logic        [DATA_W:0] u;
    logic signed [DATA_W:0] a_s;
    logic signed [DATA_W:0] b_s;
    logic signed [DATA_W:0] r_s;
    a_s = $signed({a[DATA_W-1], a});
    b_s = $signed({b[DATA_W-1], b});
    if (sub) begin
      u   = {1'b0, a} - {1'b0, b};
      r_s = a_s - b_s;
    end else begin
      u   = {1'b0, a} + {1'b0, b};
      r_s = a_s + b_s;
    end
    return {u[DATA_W], r_s[DATA_W] ^ r_s[DATA_W-1], u[DATA_W-1:0]};
  endfunction

  logic [DATA_W-1:0] f_nxt;
  logic              c_nxt;
  logic              v_nxt;

  always_comb begin
    f_nxt = '0;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (FSEL)
      OP_TSA: f_nxt = ABUS;
      OP_INC: {c_nxt, v_nxt, f_nxt} = add_sub(ABUS, ONE, 1'b0);
      OP_DEC: {c_nxt, v_nxt, f_nxt} = add_sub(ABUS, ONE, 1'b1);
      OP_ADD: {c_nxt, v_nxt, f_nxt} = add_sub(ABUS, BBUS, 1'b0);
      OP_SUB: {c_nxt, v_nxt, f_nxt} = add_sub(ABUS, BBUS, 1'b1);
      OP_AND: f_nxt = ABUS & BBUS;
      OP_OR:  f_nxt = ABUS | BBUS;
      OP_XOR: f_nxt = ABUS ^ BBUS;
      OP_NOT: f_nxt = ~ABUS;
      // Shifts and rotates flag V when the sign bit changes; ASR never does.
      OP_SHL: begin
        f_nxt = {ABUS[DATA_W-2:0], 1'b0};
        c_nxt = ABUS[DATA_W-1];
        v_nxt = ABUS[DATA_W-1] ^ f_nxt[DATA_W-1];
      end
      OP_SHR: begin
        f_nxt = {1'b0, ABUS[DATA_W-1:1]};
        c_nxt = ABUS[0];
        v_nxt = ABUS[DATA_W-1] ^ f_nxt[DATA_W-1];
      end
      OP_ASR: begin
        f_nxt = {ABUS[DATA_W-1], ABUS[DATA_W-1:1]};
        c_nxt = ABUS[0];
      end
      OP_RLC: begin
        f_nxt = {ABUS[DATA_W-2:0], CIN};
        c_nxt = ABUS[DATA_W-1];
        v_nxt = ABUS[DATA_W-1] ^ f_nxt[DATA_W-1];
      end
      OP_RRC: begin
        f_nxt = {CIN, ABUS[DATA_W-1:1]};
        c_nxt = ABUS[0];
        v_nxt = ABUS[DATA_W-1] ^ f_nxt[DATA_W-1];
      end
`ifdef ALU16_EXT_OPS_EN
      OP_SWAP: f_nxt = {ABUS[HALF-1:0], ABUS[DATA_W-1:HALF]};
      OP_NEG:  {c_nxt, v_nxt, f_nxt} = add_sub(ZERO, ABUS, 1'b1);
`endif
      default: begin
        f_nxt = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
      end
    endcase
  end

  logic [DATA_W-1:0] f_p0;
  logic              z_p0;
  logic              s_p0;
  logic              c_p0;
  logic              v_p0;

  // Stage p0: result and flags registered; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      f_p0 <= '0;
      z_p0 <= 1'b0;
      s_p0 <= 1'b0;
      c_p0 <= 1'b0;
      v_p0 <= 1'b0;
    end else begin
      f_p0 <= f_nxt;
      z_p0 <= (f_nxt == '0);
      s_p0 <= f_nxt[DATA_W-1];
      c_p0 <= c_nxt;
      v_p0 <= v_nxt;
    end
  end

  assign FOUT = f_p0;
  assign Z    = z_p0;
  assign S    = s_p0;
  assign C    = c_p0;
  assign V    = v_p0;

endmodule

// File: tb/tb_alu16.sv
// Directed and randomized checks of alu16 through an expected-result queue.
// Honours ALU16_EXT_OPS_EN for the FSEL E/F expectations.
module tb_alu16;

  typedef struct packed {
    logic [15:0] f;
    logic        z;
    logic        s;
    logic        c;
    logic        v;
  } res_t;

  logic        CLK;
  logic        RSTN;
  logic [15:0] ABUS;
  logic [15:0] BBUS;
  logic [3:0]  FSEL;
  logic        CIN;
  logic [15:0] FOUT;
  logic        Z, S, C, V;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb_q[$];

  alu16 dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .ABUS(ABUS),
    .BBUS(BBUS),
    .FSEL(FSEL),
    .CIN (CIN),
    .FOUT(FOUT),
    .Z   (Z),
    .S   (S),
    .C   (C),
    .V   (V)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(logic [15:0] f, logic z, logic s, logic c, logic v);
    res_t o;
    o.f = f; o.z = z; o.s = s; o.c = c; o.v = v;
    return o;
  endfunction

  // Reference model in integer arithmetic.
  function automatic res_t model(logic [3:0] fs, logic [15:0] a, logic [15:0] b, logic ci);
    int ua, ub, sa, sb, r, sr;
    logic [15:0] f;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 0; sr = 0;
    f = 16'h0; c = 1'b0; v = 1'b0;
    case (fs)
      4'h0: f = a;
      4'h1: begin r = ua + 1; sr = sa + 1; f = r[15:0]; c = (r > 65535); v = (sr > 32767); end
      4'h2: begin r = ua - 1; sr = sa - 1; f = r[15:0]; c = (ua < 1); v = (sr < -32768); end
      4'h3: begin r = ua + ub; sr = sa + sb; f = r[15:0]; c = (r > 65535);
                  v = (sr > 32767) || (sr < -32768); end
      4'h4: begin r = ua - ub; sr = sa - sb; f = r[15:0]; c = (ua < ub);
                  v = (sr > 32767) || (sr < -32768); end
      4'h5: f = a & b;
      4'h6: f = a | b;
      4'h7: f = a ^ b;
      4'h8: f = ~a;
      4'h9: begin f = a << 1; c = a[15]; v = a[15] ^ f[15]; end
      4'hA: begin f = a >> 1; c = a[0]; v = a[15] ^ f[15]; end
      4'hB: begin f = 16'($signed(a) >>> 1); c = a[0]; end
      4'hC: begin f = (a << 1) | 16'(ci); c = a[15]; v = a[15] ^ f[15]; end
      4'hD: begin f = (a >> 1) | {ci, 15'h0}; c = a[0]; v = a[15] ^ f[15]; end
`ifdef ALU16_EXT_OPS_EN
      4'hE: f = (a << 8) | (a >> 8);
      4'hF: begin r = 0 - ua; sr = 0 - sa; f = r[15:0]; c = (ua != 0); v = (sr > 32767); end
`endif
      default: f = 16'h0;
    endcase
    return mk(f, (f == 16'h0), f[15], c, v);
  endfunction

  task automatic check(string tag, res_t obs, res_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, queue its expectation, compare one edge later.
  task automatic drive_exp(string tag, logic [3:0] fs, logic [15:0] a, logic [15:0] b,
                           logic ci, res_t exp);
    res_t e;
    @(negedge CLK);
    FSEL = fs; ABUS = a; BBUS = b; CIN = ci;
    sb_q.push_back(exp);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, {FOUT, Z, S, C, V}, e);
    end
  endtask

  task automatic drive_op(string tag, logic [3:0] fs, logic [15:0] a, logic [15:0] b, logic ci);
    drive_exp(tag, fs, a, b, ci, model(fs, a, b, ci));
  endtask

  initial begin
    RSTN = 1'b0;
    FSEL = 4'h3; ABUS = 16'h1234; BBUS = 16'h4321; CIN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", {FOUT, Z, S, C, V}, mk(16'h0, 0, 0, 0, 0));
    @(negedge CLK);
    RSTN = 1'b1;

    drive_exp("add_8000_ffff", 4'h3, 16'h8000, 16'hFFFF, 1'b0, mk(16'h7FFF, 0, 0, 1, 1));
    drive_exp("add_7fff_0001", 4'h3, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 1, 0, 1));
    drive_exp("sub_7fff_ffff", 4'h4, 16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 0, 1, 1, 1));
    drive_exp("sub_fffc_0005", 4'h4, 16'hFFFC, 16'h0005, 1'b0, mk(16'hFFF7, 0, 1, 0, 0));
    drive_exp("rrc_0001_c1",   4'hD, 16'h0001, 16'hAAAA, 1'b1, mk(16'h8000, 0, 1, 1, 1));
    drive_exp("rlc_8001_c1",   4'hC, 16'h8001, 16'h5555, 1'b1, mk(16'h0003, 0, 0, 1, 1));
    drive_exp("shr_8001",      4'hA, 16'h8001, 16'hFFFF, 1'b1, mk(16'h4000, 0, 0, 1, 1));
    drive_exp("asr_8001",      4'hB, 16'h8001, 16'hFFFF, 1'b1, mk(16'hC000, 0, 1, 1, 0));
    drive_exp("shl_4001",      4'h9, 16'h4001, 16'h0000, 1'b1, mk(16'h8002, 0, 1, 0, 1));
    drive_exp("inc_ffff",      4'h1, 16'hFFFF, 16'h1234, 1'b1, mk(16'h0000, 1, 0, 1, 0));
    drive_exp("inc_7fff",      4'h1, 16'h7FFF, 16'h1234, 1'b0, mk(16'h8000, 0, 1, 0, 1));
    drive_exp("dec_0000",      4'h2, 16'h0000, 16'h1234, 1'b1, mk(16'hFFFF, 0, 1, 1, 0));
    drive_exp("dec_8000",      4'h2, 16'h8000, 16'h1234, 1'b0, mk(16'h7FFF, 0, 0, 0, 1));
    drive_exp("add_cin_ign",   4'h3, 16'h0001, 16'h0001, 1'b1, mk(16'h0002, 0, 0, 0, 0));
    drive_exp("not_00ff",      4'h8, 16'h00FF, 16'h1111, 1'b1, mk(16'hFF00, 0, 1, 0, 0));
    drive_exp("xor_equal",     4'h7, 16'hA5A5, 16'hA5A5, 1'b0, mk(16'h0000, 1, 0, 0, 0));
`ifdef ALU16_EXT_OPS_EN
    drive_exp("swap_1234",     4'hE, 16'h1234, 16'hFFFF, 1'b1, mk(16'h3412, 0, 0, 0, 0));
    drive_exp("neg_8000",      4'hF, 16'h8000, 16'h0000, 1'b0, mk(16'h8000, 0, 1, 1, 1));
    drive_exp("neg_0000",      4'hF, 16'h0000, 16'h0000, 1'b0, mk(16'h0000, 1, 0, 0, 0));
`else
    drive_exp("swap_1234",     4'hE, 16'h1234, 16'hFFFF, 1'b1, mk(16'h0000, 1, 0, 0, 0));
    drive_exp("neg_8000",      4'hF, 16'h8000, 16'h0000, 1'b0, mk(16'h0000, 1, 0, 0, 0));
`endif

    // Asynchronous reset: take it mid-cycle after a nonzero-flag result.
    drive_exp("add_wrap",      4'h3, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 0, 1, 0));
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_async", {FOUT, Z, S, C, V}, mk(16'h0, 0, 0, 0, 0));
    FSEL = 4'h4; ABUS = 16'h0000; BBUS = 16'h0001;
    @(posedge CLK);
    #1;
    check("rst_hold", {FOUT, Z, S, C, V}, mk(16'h0, 0, 0, 0, 0));
    @(negedge CLK);
    RSTN = 1'b1;
    FSEL = 4'h4; ABUS = 16'h0000; BBUS = 16'h0001; CIN = 1'b0;
    sb_q.push_back(mk(16'hFFFF, 0, 1, 1, 0));
    @(posedge CLK);
    #1;
    check("first_after_rst", {FOUT, Z, S, C, V}, sb_q.pop_front());

    for (int i = 0; i < 64; i++) begin
      drive_op("rand", 4'(i % 16), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
